set_assoc_cache: RTL

Two-way set-associative, write-back, write-allocate data cache with a configurable block size. It is the successor to the team's direct-mapped cache. The block owns its own miss handling: an internal FSM writes back a dirty victim and refills the line over a word-serial burst to main memory, so the controller only needs to wait on Ready. It sits between the processor load/store port and the main-memory block.

---
 rtl/set_assoc_cache.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/set_assoc_cache.sv
// Two-way set-associative, write-back, write-allocate data cache.
// Hits complete in the cycle they are presented. A miss picks a victim,
// writes it back word by word if it is dirty, refills it word by word, and
// then lets IDLE look the request up again so that it completes as a hit.
//
// Memory beat handshake: while mem_req is high, the beat described by
// mem_we/mem_addr/mem_wdata is held stable. It completes in the cycle
// mem_ack is high, and refill data is taken from mem_rdata in that cycle.
module set_assoc_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int SETS       = 16,
  parameter int WORDS      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  Mem_Rd,
  input  logic                  Mem_Wr,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] Data_in,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  Ready,
  output logic                  Miss,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count,
  output logic [1:0]            state_dbg
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Line state; valid/dirty/lru are reset, tags and data are not.
  logic [SETS-1:0]       valid_q [2];
  logic [SETS-1:0]       dirty_q [2];
  logic [SETS-1:0]       lru_q;
  logic [TAG_W-1:0]      tag_q   [2][SETS];
  logic [DATA_WIDTH-1:0] data_q  [2][SETS][WORDS];

  logic [OFF_W-1:0] beat_q;
  logic             victim_way_q;
  logic [TAG_W-1:0] victim_tag_q;
  logic             init_q;      // first cycle after reset: requests ignored
  logic             refilled_q;  // lookup right after a refill is not a fresh hit

  // Request decode
  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             req, hit0, hit1, hit, hit_way;
  logic             victim_way, victim_dirty, last_beat;
  logic             do_hit, do_miss;

  assign req_off = Address[OFF_W-1:0];
  assign req_idx = Address[OFF_W +: IDX_W];
  assign req_tag = Address[ADDR_WIDTH-1 -: TAG_W];

  assign req  = (Mem_Rd | Mem_Wr) & ~rst & ~init_q;
  assign hit0 = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
  assign hit1 = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
  assign hit  = hit0 | hit1;
  // Both ways hitting cannot happen: a line is only ever filled after a miss.
  assign hit_way = ~hit0;

  assign victim_way   = !valid_q[0][req_idx] ? 1'b0 :
                        !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
  assign victim_dirty = valid_q[victim_way][req_idx] && dirty_q[victim_way][req_idx];
  assign last_beat    = (beat_q == OFF_W'(WORDS - 1));

  assign Data_out  = data_q[hit_way][req_idx][req_off];
  assign state_dbg = state_q;

  // Next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    Ready     = 1'b0;
    Miss      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {req_tag, req_idx, beat_q};
    mem_wdata = data_q[victim_way_q][req_idx][beat_q];
    do_hit    = 1'b0;
    do_miss   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            Ready  = 1'b1;
            do_hit = 1'b1;
          end else begin
            Miss    = 1'b1;
            do_miss = 1'b1;
            state_d = victim_dirty ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {victim_tag_q, req_idx, beat_q};
        if (mem_ack && last_beat) state_d = REFILL;
      end
      REFILL: begin
        mem_req = 1'b1;
        if (mem_ack && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      state_d = IDLE;
    end
  end

  // Control state, line status bits and counters
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      valid_q[0]   <= '0;
      valid_q[1]   <= '0;
      dirty_q[0]   <= '0;
      dirty_q[1]   <= '0;
      lru_q        <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
      victim_way_q <= 1'b0;
      victim_tag_q <= '0;
      init_q       <= 1'b1;
      refilled_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_q     <= 1'b0;
      refilled_q <= (state_q == REFILL) && mem_ack && last_beat;
      if (do_hit) begin
        lru_q[req_idx] <= ~hit_way;
        if (Mem_Wr) dirty_q[hit_way][req_idx] <= 1'b1;
        if (!refilled_q && hit_count != {CNT_WIDTH{1'b1}})
          hit_count <= hit_count + 1'b1;
      end
      if (do_miss) begin
        victim_way_q <= victim_way;
        victim_tag_q <= tag_q[victim_way][req_idx];
        // The line is invalid from now until its refill completes.
        valid_q[victim_way][req_idx] <= 1'b0;
        if (miss_count != {CNT_WIDTH{1'b1}})
          miss_count <= miss_count + 1'b1;
      end
      if (state_q == WRITEBACK && mem_ack) begin
        beat_q <= last_beat ? '0 : beat_q + 1'b1;
        if (last_beat) dirty_q[victim_way_q][req_idx] <= 1'b0;
      end
      if (state_q == REFILL && mem_ack) begin
        beat_q <= last_beat ? '0 : beat_q + 1'b1;
        if (last_beat) begin
          valid_q[victim_way_q][req_idx] <= 1'b1;
          dirty_q[victim_way_q][req_idx] <= 1'b0;
        end
      end
    end
  end

  // Tag and data arrays: refill beats and write hits
  always_ff @(posedge CLK) begin
    if (!rst && state_q == REFILL && mem_ack) begin
      data_q[victim_way_q][req_idx][beat_q] <= mem_rdata;
      if (last_beat) tag_q[victim_way_q][req_idx] <= req_tag;
    end else if (do_hit && Mem_Wr) begin
      data_q[hit_way][req_idx][req_off] <= Data_in;
    end
  end

endmodule
